// File: rtl/fifo_flex.sv
// Synchronous valid/ready FIFO with arbitrary depth, optional output register,
// runtime almost-full/empty thresholds, occupancy count, high-water mark and flush.
module fifo_flex #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int OUT_REG = 0,
    parameter int CW      = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    input  logic [CW-1:0]    af_level,
    input  logic [CW-1:0]    ae_level,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    hwm,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CAP  = CW'(DEPTH + OUT_REG);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    mcnt_q, mcnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    hwm_q, hwm_d;
    logic             wr_xfer, rd_xfer, pop, mem_nz;

    assign mem_nz   = (mcnt_q != '0);
    assign full     = (cnt_q == CAP);
    assign empty    = (cnt_q == '0);
    assign wr_ready = ~full & ~flush & rstn;
    assign wr_xfer  = wr_valid & wr_ready;
    // A read handshake during flush is not honoured
    assign rd_xfer  = rd_valid & rd_ready & ~flush;

    assign count        = cnt_q;
    assign hwm          = hwm_q;
    assign almost_full  = (cnt_q >= af_level);
    assign almost_empty = (cnt_q <= ae_level);

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic             ov_q, ov_d;
            logic [WIDTH-1:0] od_q, od_d;

            always_comb begin
                ov_d = ov_q;
                od_d = od_q;
                pop  = 1'b0;
                if (flush) begin
                    ov_d = 1'b0;
                end else if (mem_nz && (!ov_q || rd_xfer)) begin
                    pop  = 1'b1;
                    ov_d = 1'b1;
                    od_d = mem_q[rp_q];
                end else if (rd_xfer) begin
                    ov_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    ov_q <= 1'b0;
                    od_q <= '0;
                end else begin
                    ov_q <= ov_d;
                    od_q <= od_d;
                end
            end

            assign rd_valid = ov_q;
            assign rd_data  = od_q;
        end else begin : g_fwft
            assign pop      = rd_xfer;
            assign rd_valid = mem_nz;
            assign rd_data  = mem_q[rp_q];
        end
    endgenerate

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        mcnt_d = mcnt_q;
        cnt_d  = cnt_q;
        hwm_d  = hwm_q;
        if (flush) begin
            wp_d   = '0;
            rp_d   = '0;
            mcnt_d = '0;
            cnt_d  = '0;
            hwm_d  = '0;
        end else begin
            if (wr_xfer) begin
                wp_d = (wp_q == LAST) ? '0 : wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = (rp_q == LAST) ? '0 : rp_q + PW'(1);
            end
            mcnt_d = mcnt_q + CW'(wr_xfer) - CW'(pop);
            cnt_d  = cnt_q + CW'(wr_xfer) - CW'(rd_xfer);
            hwm_d  = (cnt_d > hwm_q) ? cnt_d : hwm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp_q   <= '0;
            rp_q   <= '0;
            mcnt_q <= '0;
            cnt_q  <= '0;
            hwm_q  <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            mcnt_q <= mcnt_d;
            cnt_q  <= cnt_d;
            hwm_q  <= hwm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_xfer) begin
            mem_q[wp_q] <= wr_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (cnt_q <= CAP)
                else $error("fifo_flex: count above capacity");
            assert (!(rd_xfer && !wr_xfer && cnt_q == '0))
                else $error("fifo_flex: count underflow");
            assert (!(wr_xfer && !rd_xfer && cnt_q == CAP))
                else $error("fifo_flex: count overflow");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a fall-through and a registered-output instance run the
// same stimulus and are compared every cycle against queue-based models.
module tb_fifo_flex;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rstn, flush, wv, rr;
    logic [7:0]    wd;
    logic [CW-1:0] af, ae;

    logic          a_wr_ready, a_rd_valid, a_full, a_empty, a_af, a_ae;
    logic [7:0]    a_rd_data;
    logic [CW-1:0] a_count, a_hwm;
    logic          b_wr_ready, b_rd_valid, b_full, b_empty, b_af, b_ae;
    logic [7:0]    b_rd_data;
    logic [CW-1:0] b_count, b_hwm;

    int ncmp = 0;
    int nerr = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         ovb;
    logic [7:0] odb;
    int         hwa, hwb;

    always #5 clk = ~clk;

    fifo_flex #(.WIDTH(8), .DEPTH(5), .OUT_REG(0)) ua (
        .clk(clk), .rstn(rstn), .flush(flush),
        .wr_valid(wv), .wr_ready(a_wr_ready), .wr_data(wd),
        .rd_valid(a_rd_valid), .rd_ready(rr), .rd_data(a_rd_data),
        .af_level(af), .ae_level(ae), .count(a_count), .hwm(a_hwm),
        .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae)
    );

    fifo_flex #(.WIDTH(8), .DEPTH(5), .OUT_REG(1)) ub (
        .clk(clk), .rstn(rstn), .flush(flush),
        .wr_valid(wv), .wr_ready(b_wr_ready), .wr_data(wd),
        .rd_valid(b_rd_valid), .rd_ready(rr), .rd_data(b_rd_data),
        .af_level(af), .ae_level(ae), .count(b_count), .hwm(b_hwm),
        .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ca, cb;
        ca = qa.size();
        cb = qb.size() + int'(ovb);
        chk("A.wr_ready", a_wr_ready, 32'(ca < 5 && !flush && rstn));
        chk("A.rd_valid", a_rd_valid, 32'(ca > 0));
        if (ca > 0) chk("A.rd_data", a_rd_data, qa[0]);
        chk("A.count", a_count, ca);
        chk("A.full", a_full, 32'(ca == 5));
        chk("A.empty", a_empty, 32'(ca == 0));
        chk("A.almost_full", a_af, 32'(ca >= int'(af)));
        chk("A.almost_empty", a_ae, 32'(ca <= int'(ae)));
        chk("A.hwm", a_hwm, hwa);
        chk("B.wr_ready", b_wr_ready, 32'(cb < 6 && !flush && rstn));
        chk("B.rd_valid", b_rd_valid, 32'(ovb));
        if (ovb) chk("B.rd_data", b_rd_data, odb);
        chk("B.count", b_count, cb);
        chk("B.full", b_full, 32'(cb == 6));
        chk("B.empty", b_empty, 32'(cb == 0));
        chk("B.almost_full", b_af, 32'(cb >= int'(af)));
        chk("B.almost_empty", b_ae, 32'(cb <= int'(ae)));
        chk("B.hwm", b_hwm, hwb);
    endtask

    task automatic model_update();
        bit wa, ra, wb, rb;
        int cb;
        if (!rstn || flush) begin
            qa.delete();
            qb.delete();
            ovb = 1'b0;
            hwa = 0;
            hwb = 0;
            if (!rstn) odb = '0;
        end else begin
            wa = wv && qa.size() < 5;
            ra = qa.size() > 0 && rr;
            if (ra) void'(qa.pop_front());
            if (wa) qa.push_back(wd);
            if (qa.size() > hwa) hwa = qa.size();

            cb = qb.size() + int'(ovb);
            wb = wv && cb < 6;
            rb = ovb && rr;
            if (qb.size() > 0 && (!ovb || rb)) begin
                odb = qb.pop_front();
                ovb = 1'b1;
            end else if (rb) begin
                ovb = 1'b0;
            end
            if (wb) qb.push_back(wd);
            cb = qb.size() + int'(ovb);
            if (cb > hwb) hwb = cb;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; wv = 1'b0; rr = 1'b0;
        wd = '0; af = 3'd4; ae = 3'd1;
        ovb = 1'b0; odb = '0; hwa = 0; hwb = 0;
        @(posedge clk);
        #1;
        cycle();
        chk("reset.count", a_count, 0);
        chk("reset.empty", a_empty, 1);
        chk("reset.b_rd_valid", b_rd_valid, 0);
        rstn = 1'b1;

        for (int i = 1; i <= 6; i++) begin
            wv = 1'b1; wd = 8'(i);
            cycle();
        end
        chk("fill.A_full", a_full, 1);
        chk("fill.A_count", a_count, 5);
        chk("fill.A_wr_ready", a_wr_ready, 0);
        chk("fill.B_count", b_count, 6);
        chk("fill.B_full", b_full, 1);
        repeat (2) cycle();
        wv = 1'b0; rr = 1'b1;
        repeat (8) cycle();
        chk("drain.A_empty", a_empty, 1);
        chk("drain.B_empty", b_empty, 1);

        flush = 1'b1; rr = 1'b0;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wv = 1'b1; wd = 8'h10 + 8'(i); rr = 1'b1;
            cycle();
            if (i > 0) chk("stream.A_count", a_count, 1);
        end
        chk("stream.A_hwm", a_hwm, 1);
        wv = 1'b0;
        repeat (3) cycle();

        rr = 1'b0; wv = 1'b1; wd = 8'h55;
        cycle();
        wv = 1'b0;
        chk("lat.A_n1", a_rd_valid, 1);
        chk("lat.B_n1", b_rd_valid, 0);
        cycle();
        chk("lat.B_n2", b_rd_valid, 1);
        repeat (3) begin
            cycle();
            chk("hold.B_data", b_rd_data, 8'h55);
        end
        rr = 1'b1;
        repeat (3) cycle();

        rr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wv = 1'b1; wd = 8'h20 + 8'(i);
            cycle();
        end
        wv = 1'b0;
        chk("thr.A_af", a_af, 1);
        chk("thr.A_ae", a_ae, 0);
        rr = 1'b1;
        repeat (3) cycle();
        rr = 1'b0;
        chk("thr.A_count1", a_count, 1);
        chk("thr.A_ae1", a_ae, 1);
        rr = 1'b1;
        repeat (3) cycle();

        rr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wv = 1'b1; wd = 8'h30 + 8'(i);
            cycle();
        end
        flush = 1'b1; wv = 1'b1; wd = 8'h3F; rr = 1'b1;
        cycle();
        flush = 1'b0; wv = 1'b0; rr = 1'b0;
        chk("flush.A_count", a_count, 0);
        chk("flush.A_hwm", a_hwm, 0);
        chk("flush.A_rd_valid", a_rd_valid, 0);
        chk("flush.B_count", b_count, 0);
        wv = 1'b1; wd = 8'hAA;
        cycle();
        wv = 1'b0;
        cycle();
        chk("flush.A_next", a_rd_data, 8'hAA);
        chk("flush.B_next", b_rd_data, 8'hAA);
        rr = 1'b1;
        repeat (3) cycle();

        rr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wv = 1'b1; wd = 8'h40 + 8'(i);
            cycle();
        end
        rstn = 1'b0;
        cycle();
        rstn = 1'b1; wv = 1'b0;
        chk("rst.A_count", a_count, 0);
        chk("rst.A_hwm", a_hwm, 0);
        chk("rst.B_empty", b_empty, 1);
        wv = 1'b1; wd = 8'hBB;
        cycle();
        wv = 1'b0; rr = 1'b1;
        repeat (3) cycle();

        for (int i = 0; i < 800; i++) begin
            wv    = 1'($urandom_range(0, 99) < 60);
            rr    = 1'($urandom_range(0, 99) < 50);
            wd    = 8'($urandom);
            flush = 1'($urandom_range(0, 39) == 0);
            rstn  = !($urandom_range(0, 79) == 0);
            if (i % 50 == 0) begin
                af = 3'($urandom_range(0, 7));
                ae = 3'($urandom_range(0, 7));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised synchronous valid/ready FIFO. It is the general-purpose buffer for commctrl stream paths. Compared with the basic fifo it supports:
- any integer DEPTH (not only powers of two),
- an optional registered output stage,
- runtime almost-full/almost-empty thresholds,
- an occupancy count, a high-water mark, and a synchronous flush.

It sits between strm_intf producers and consumers. Its ports are flattened so the block can be wrapped by either interface side.

Parameters:
WIDTH, 16, data word width in bits (>=1).
DEPTH, 8, memory entries (>=2, any integer).
OUT_REG, 0, 0 = first-word-fall-through from memory; 1 = extra output register stage.
CW, $clog2(DEPTH+2), width of count/threshold fields (derived; do not override).

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  reset, synchronous, active-low
flush  in  1  synchronous clear of all stored words
wr_valid  in  1  producer has data
wr_ready  out  1  FIFO accepts data
wr_data  in  WIDTH  write word
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer accepts word
rd_data  out  WIDTH  read word
af_level  in  CW  almost-full threshold
ae_level  in  CW  almost-empty threshold
count  out  CW  words held (memory + output register)
hwm  out  CW  peak count since reset/flush
full  out  1  count == CAP
empty  out  1  count == 0
almost_full  out  1  count >= af_level
almost_empty  out  1  count <= ae_level

Behaviour:
- Capacity: CAP = DEPTH + OUT_REG.
- Transfers: wr_xfer = wr_valid & wr_ready; rd_xfer = rd_valid & rd_ready.
- wr_ready = ~full & ~flush & rstn. There is no write pass-through when full, even with a simultaneous read.
- Reset (rstn=0 at a clock edge): pointers, count, hwm, rd_valid and the output register all go to 0. empty=1, full=0, wr_ready=0 while rstn is low. Memory contents are not reset.
- Reset applied mid-operation discards all data. There is no partial state.
- Pointers wrap from DEPTH-1 to 0. Never use modulo-2^n wrap.
- Count update: count_next = count + wr_xfer - rd_xfer. Simultaneous write and read leaves count unchanged.
- Count saturation: count never exceeds CAP and never underflows. Assertions must cover both.
- OUT_REG=0 latency:
  - rd_valid = (mem words > 0); rd_data = mem[rd_ptr].
  - A word written at edge N is visible with rd_valid=1 in cycle N+1.
- OUT_REG=1 latency:
  - The output register loads mem[rd_ptr] when (register empty | rd_xfer) and the memory is non-empty.
  - A word written at edge N first appears in cycle N+2.
  - Sustained throughput is 1 word/cycle.
- Hold rule: while rd_valid=1 and rd_ready=0, rd_data and rd_valid must hold stable.
- FIFO order: words are delivered in exact FIFO order with no duplication.
- Flags are derived from the registered count, so they change only on clock edges:
  - full, empty, almost_full (count >= af_level), almost_empty (count <= ae_level).
  - af_level=0 forces almost_full=1.
  - ae_level >= CAP forces almost_empty=1.
- hwm: register that takes max(hwm, count_next) each cycle. It is cleared by reset and by flush.
- Flush:
  - In the flush cycle, wr_ready=0 and any rd handshake is ignored (no pointer movement).
  - At the next edge: pointers, count, hwm and rd_valid go to 0. Memory is not cleared.
  - Flush has priority over all transfers. Back-to-back flush cycles are legal.
- Reset has priority over flush.

Test Plan:
- WIDTH=8, DEPTH=5, OUT_REG=0; write 0x01..0x05 with rd_ready=0 -> count=5, full=1, wr_ready=0. A sixth write 0x06 is held with no acceptance. Then read -> 0x01..0x05 in order, empty=1.
- DEPTH=5, OUT_REG=0; continuous write+read for 12 words (pointer wraps twice) -> data order preserved, count stays 1, hwm=1.
- OUT_REG=1, DEPTH=5; single write at edge N -> rd_valid rises in cycle N+2. Fill -> full asserts at count=6. Stall rd_ready=0 for 3 cycles -> rd_data stable.
- af_level=4, ae_level=1; write 4 words -> almost_full rises with count=4, almost_empty falls at count=2. Read down to 1 -> almost_empty=1.
- Write 3 words, then assert flush with wr_valid=1 and rd_ready=1 -> the flush-cycle transfers are ignored. Next cycle count=0, hwm=0, empty=1, rd_valid=0. Write 0xAA -> 0xAA is the next word read.
- Hold rstn=0 for one cycle while count=4 and wr_valid=1 -> count=0, empty=1, hwm=0, wr_ready=0 during reset. After release, normal operation resumes with no stale data.
